// File: rtl/mem_sp_arb.sv
// Two-port round-robin arbiter with burst lock in front of a single-port RAM.
// Port 0 serves the NTT butterfly datapath, port 1 the host load/unload engine.
// Read data comes back one cycle after the grant, tagged to the issuing port.
module mem_sp_arb #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic             lock0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic             lock1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_di,
  input  logic [WIDTH-1:0] mem_do
);

  logic             last;
  logic             lock_act;
  logic             lock_own;
  logic             rd_pend0;
  logic             rd_pend1;
  logic [WIDTH-1:0] rdata_hold0;
  logic [WIDTH-1:0] rdata_hold1;

  // Grant selection: a held lock wins, otherwise a tie goes to the port not served last.
  // Grants are gated by rst_n so the memory is idle while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (lock_act && (lock_own ? req1 : req0)) begin
        gnt0 = !lock_own;
        gnt1 = lock_own;
      end else if (req0 && req1) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Memory pin mux from the granted port; address and data park at zero when idle.
  always_comb begin
    mem_en   = gnt0 | gnt1;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_di   = wdata1;
    end else if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_di   = wdata0;
    end
  end

  // Arbitration history, lock tracking and read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      lock_act <= 1'b0;
      lock_own <= 1'b0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else if (gnt0 || gnt1) begin
      last     <= gnt1;
      lock_act <= gnt1 ? lock1 : lock0;
      lock_own <= gnt1;
      rd_pend0 <= gnt0 & ~we0;
      rd_pend1 <= gnt1 & ~we1;
    end else begin
      lock_act <= 1'b0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end
  end

  // Per-port copy of the last returned read word, so rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold0 <= '0;
      rdata_hold1 <= '0;
    end else begin
      if (rd_pend0) rdata_hold0 <= mem_do;
      if (rd_pend1) rdata_hold1 <= mem_do;
    end
  end

  // mem_do is already registered in the RAM, so the return cycle forwards it directly.
  assign rvalid0 = rd_pend0;
  assign rvalid1 = rd_pend1;
  assign rdata0  = rd_pend0 ? mem_do : rdata_hold0;
  assign rdata1  = rd_pend1 ? mem_do : rdata_hold1;

endmodule

// File: tb/tb_mem_sp_arb.sv
// Directed bench for mem_sp_arb with a write-first single-port RAM model.
module tb_mem_sp_arb;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic [AW-1:0]    addr0 = '0;
  logic [WIDTH-1:0] wdata0 = '0;
  logic             req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0]    addr1 = '0;
  logic [WIDTH-1:0] wdata1 = '0;
  logic             gnt0, rvalid0, gnt1, rvalid1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_di;
  logic [WIDTH-1:0] mem_do = '0;
  logic [WIDTH-1:0] mem_arr [DEPTH];

  int checks = 0;
  int failures = 0;

  mem_sp_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM: do echoes write data, else returns the stored word.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr] <= mem_di;
        mem_do            <= mem_di;
      end else begin
        mem_do <= mem_arr[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, then settle before checking.
  task automatic step(input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0,
                      input logic [WIDTH-1:0] d0, input logic r1, input logic w1, input logic l1,
                      input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    chk("one_hot_gnt", 32'(gnt0 & gnt1), 32'd0);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_gnt0", 32'(gnt0), 0);      chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0); chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_rdata0", 32'(rdata0), 0);  chk("rst_rdata1", 32'(rdata1), 0);
    chk("rst_mem_en", 32'(mem_en), 0);  chk("rst_mem_we", 32'(mem_we), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: port 0 writes A5 to addr 5
    step(1, 1, 0, 6'd5, 8'hA5, 0, 0, 0, 6'd0, 8'h00);
    chk("t1_gnt0", 32'(gnt0), 1);  chk("t1_gnt1", 32'(gnt1), 0);
    chk("t1_mem_we", 32'(mem_we), 1); chk("t1_mem_addr", 32'(mem_addr), 5);
    chk("t1_mem_di", 32'(mem_di), 32'hA5);
    // T2: port 0 reads addr 5
    step(1, 0, 0, 6'd5, 8'h00, 0, 0, 0, 6'd0, 8'h00);
    chk("t2_gnt0", 32'(gnt0), 1);  chk("t2_mem_we", 32'(mem_we), 0);
    chk("t2_rvalid0_wr", 32'(rvalid0), 0);
    // T3: port 1 writes 3C to addr 7; port 0 read returns concurrently
    step(0, 0, 0, 6'd0, 8'h00, 1, 1, 0, 6'd7, 8'h3C);
    chk("t3_rvalid0", 32'(rvalid0), 1); chk("t3_rdata0", 32'(rdata0), 32'hA5);
    chk("t3_rvalid1", 32'(rvalid1), 0); chk("t3_gnt1", 32'(gnt1), 1);
    chk("t3_mem_addr", 32'(mem_addr), 7);
    // T4: port 0 reads addr 7
    step(1, 0, 0, 6'd7, 8'h00, 0, 0, 0, 6'd0, 8'h00);
    chk("t4_gnt0", 32'(gnt0), 1);
    chk("t4_rvalid0", 32'(rvalid0), 0); chk("t4_rvalid1_wr", 32'(rvalid1), 0);
    // T5: port 1 reads addr 5; port 0 gets 3C
    step(0, 0, 0, 6'd0, 8'h00, 1, 0, 0, 6'd5, 8'h00);
    chk("t5_rvalid0", 32'(rvalid0), 1); chk("t5_rdata0", 32'(rdata0), 32'h3C);
    chk("t5_rvalid1", 32'(rvalid1), 0); chk("t5_gnt1", 32'(gnt1), 1);

    // T6..T9: both ports read, last=1 so grants alternate 0,1,0,1
    step(1, 0, 0, 6'd7, 8'h00, 1, 0, 0, 6'd5, 8'h00);
    chk("t6_gnt0", 32'(gnt0), 1); chk("t6_mem_addr", 32'(mem_addr), 7);
    chk("t6_rvalid1", 32'(rvalid1), 1); chk("t6_rdata1", 32'(rdata1), 32'hA5);
    step(1, 0, 0, 6'd7, 8'h00, 1, 0, 0, 6'd5, 8'h00);
    chk("t7_gnt1", 32'(gnt1), 1); chk("t7_mem_addr", 32'(mem_addr), 5);
    chk("t7_rvalid0", 32'(rvalid0), 1); chk("t7_rvalid1", 32'(rvalid1), 0);
    chk("t7_rdata0", 32'(rdata0), 32'h3C);
    step(1, 0, 0, 6'd7, 8'h00, 1, 0, 0, 6'd5, 8'h00);
    chk("t8_gnt0", 32'(gnt0), 1); chk("t8_mem_addr", 32'(mem_addr), 7);
    chk("t8_rvalid1", 32'(rvalid1), 1); chk("t8_rvalid0", 32'(rvalid0), 0);
    step(1, 0, 0, 6'd7, 8'h00, 1, 0, 0, 6'd5, 8'h00);
    chk("t9_gnt1", 32'(gnt1), 1); chk("t9_rvalid0", 32'(rvalid0), 1);

    // T10, T11: idle; memory parked, rdata holds
    step(0, 0, 0, 6'd9, 8'h00, 0, 0, 0, 6'd9, 8'h00);
    chk("t10_mem_en", 32'(mem_en), 0); chk("t10_mem_addr", 32'(mem_addr), 0);
    chk("t10_rvalid1", 32'(rvalid1), 1); chk("t10_rdata1", 32'(rdata1), 32'hA5);
    step(0, 0, 0, 6'd9, 8'h00, 0, 0, 0, 6'd9, 8'h00);
    chk("t11_rvalid0", 32'(rvalid0), 0); chk("t11_rvalid1", 32'(rvalid1), 0);
    chk("t11_rdata0_hold", 32'(rdata0), 32'h3C); chk("t11_rdata1_hold", 32'(rdata1), 32'hA5);

    // T12: port 0 alone so that last=0 before the lock burst
    step(1, 0, 0, 6'd7, 8'h00, 0, 0, 0, 6'd0, 8'h00);
    chk("t12_gnt0", 32'(gnt0), 1);
    // T13..T15: port 1 locks for three cycles against a pending port 0
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 6'd7, 8'h00, 1, 0, 1, 6'd5, 8'h00);
      chk("lock_gnt1", 32'(gnt1), 1); chk("lock_gnt0", 32'(gnt0), 0);
      chk("lock_mem_addr", 32'(mem_addr), 5);
    end
    // T16: lock and req released, port 0 wins
    step(1, 0, 0, 6'd7, 8'h00, 0, 0, 0, 6'd5, 8'h00);
    chk("t16_gnt0", 32'(gnt0), 1); chk("t16_gnt1", 32'(gnt1), 0);
    chk("t16_rvalid1", 32'(rvalid1), 1); chk("t16_rdata1", 32'(rdata1), 32'hA5);

    // T17: read granted, then reset asserted before the return
    step(1, 0, 0, 6'd7, 8'h00, 0, 0, 0, 6'd0, 8'h00);
    chk("t17_gnt0", 32'(gnt0), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid0", 32'(rvalid0), 0); chk("rst_mid_mem_en", 32'(mem_en), 0);
    chk("rst_mid_gnt0", 32'(gnt0), 0);       chk("rst_mid_rdata0", 32'(rdata0), 0);
    @(negedge clk);
    #1;
    chk("rst_hold_rvalid0", 32'(rvalid0), 0);
    // T18: release reset with a tie; port 0 must win first
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1; we0 = 0; addr0 = 6'd7; req1 = 1; we1 = 0; addr1 = 6'd5;
    #1;
    chk("post_rst_gnt0", 32'(gnt0), 1); chk("post_rst_gnt1", 32'(gnt1), 0);
    // T19: port 1 now; port 0 read of addr 7 returns 3C
    step(1, 0, 0, 6'd7, 8'h00, 1, 0, 0, 6'd5, 8'h00);
    chk("t19_gnt1", 32'(gnt1), 1);
    chk("t19_rvalid0", 32'(rvalid0), 1); chk("t19_rdata0", 32'(rdata0), 32'h3C);

    step(0, 0, 0, 6'd0, 8'h00, 0, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sp_arb.md
Name: mem_sp_arb

Overview:
- Two-requester arbiter that shares one single-port block RAM (the team's single-port memory, write-first read mode) between the NTT butterfly datapath (port 0) and the host load/unload engine (port 1).
- Arbitration is round-robin with an optional burst lock.
- Read data returns with a fixed 1-cycle latency and is tagged back to the requester that issued the read.
- Sits between the NTT control FSM / host bridge and the memory instance: drives its en/we/addr/di pins and consumes its do pin.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 64, memory depth in words.
- AW = CLOG2(DEPTH): derived localparam, address width. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- lock0  in  1  port 0 burst lock; keep grant while asserted.
- addr0  in  AW  port 0 address.
- wdata0  in  WIDTH  port 0 write data.
- gnt0  out  1  port 0 access accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  WIDTH  port 0 read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_di  out  WIDTH  memory write data.
- mem_do  in  WIDTH  memory read data (registered inside memory, 1-cycle latency).

Behaviour:
- Reset values while rst_n=0: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, mem_en=0, mem_we=0. rst_n has asynchronous effect on all state registers.
- State registers:
  - last (1 bit): last granted port. Resets to 1, so port 0 wins the first tie.
  - lock_act (1 bit) and lock_own (1 bit): active burst lock and its owner. Reset to 0.
  - rd_pend0, rd_pend1: read return pipeline. Reset to 0.
- Grant (combinational, same cycle as request):
  - lock_act=1 and req of lock_own=1: that port is granted; the other port is blocked.
  - Otherwise, only one req high: that port is granted.
  - Otherwise, both req high: grant goes to the port that is not `last`.
  - No req: no grant; mem_en=0.
  - At most one gnt is high in any cycle.
- Memory drive: mem_en = gnt0|gnt1. mem_we/mem_addr/mem_di are muxed from the granted port. mem_addr and mem_di are 0 when no port is granted.
- Registered updates on each rising edge with a grant to port g:
  - last <= g.
  - lock_act <= lock_g; lock_own <= g.
  - rd_pend_g <= ~we_g; the other rd_pend <= 0.
- Registered updates on a rising edge with no grant: rd_pend0, rd_pend1 and lock_act <= 0.
- Lock release: the locked port deasserts lock or req. The other port's pending req wins the next cycle, if present.
- Read return:
  - rvalid_g = rd_pend_g, i.e. one cycle after the grant.
  - rdata_g is a registered copy of mem_do, updated only when rd_pend_g=1. It holds its last value otherwise.
  - Writes never raise rvalid, even though the memory echoes write data on do.
- Back-to-back: a new grant is legal every cycle. A read granted in cycle N returns in cycle N+1, concurrent with the grant in N+1.
- Fairness: with no locks, each port waits at most 1 cycle. A locked port can starve the other indefinitely; enforcing burst length is the requester's responsibility.
- Reset mid-operation: pending rvalid is dropped, the lock is cleared, and last returns to 1.

Test Plan:
- Reset, then req0=1 we0=1 addr0=5 wdata0=0xA5 for one cycle, then req0=1 we0=0 addr0=5 → gnt0=1 both cycles. mem_we=1 in cycle 1 only. rvalid0=1 with rdata0=0xA5 in cycle 3. rvalid1 stays 0.
- req0 and req1 both high, reads for 4 cycles → grants go 0,1,0,1. rvalid0 and rvalid1 alternate one cycle later. mem_addr matches the granted port each cycle.
- Port 1 lock1=1 req1=1 for 3 cycles while req0=1 → gnt1=1 for 3 cycles, gnt0=0. Cycle 4 with lock1=0 and req1=0 → gnt0=1.
- Port 1 writes 0x3C to addr 7, then port 0 reads addr 7 the next cycle → rvalid0=1 and rdata0=0x3C. rvalid1 is never asserted.
- rst_n driven low one cycle after a read grant → rvalid0 stays 0 and mem_en=0 immediately. After release, a tie grants port 0 first.
- Idle cycles between requests → mem_en=0, rvalid low, rdata holds its previous value.
